// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: op encodings and the modular
// PC adder used for stepping, branching and return-address generation.
package pc_seq_pkg;

  // Working width of the adder. It must cover PC_W + 1 so that STEP can
  // be passed as a non-negative displacement. This limits PC_W to 32.
  localparam int MAX_W = 33;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_NEXT   = 3'd1,
    OP_JUMP   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } op_e;

  // Sign-extends the low deltaW bits of delta, adds it to base and reduces
  // the sum modulo 2^pcW. The result is {wrap, sum}. The wrap bit is set
  // when the exact sum leaves the range [0, 2^pcW).
  function automatic logic [MAX_W:0] addWrap(input logic [MAX_W-1:0] base,
                                             input logic [MAX_W-1:0] delta,
                                             input int deltaW,
                                             input int pcW);
    logic [MAX_W+1:0] highMask;
    logic [MAX_W+1:0] deltaWide;
    logic signed [MAX_W+1:0] ext;
    logic signed [MAX_W+1:0] sum;
    logic signed [MAX_W+1:0] lim;
    logic [MAX_W-1:0] res;
    logic sgn;
    highMask  = {(MAX_W+2){1'b1}} << deltaW;
    deltaWide = {2'b00, delta};
    sgn       = |(deltaWide & ((MAX_W+2)'(1) << (deltaW - 1)));
    ext       = sgn ? (deltaWide | highMask) : (deltaWide & ~highMask);
    sum       = $signed({2'b00, base}) + ext;
    lim       = (MAX_W+2)'(1) << pcW;
    res       = sum[MAX_W-1:0] & ~({MAX_W{1'b1}} << pcW);
    return {(sum < 0) || (sum >= lim), res};
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO of return addresses. The fill count drives full and empty, so the
// slot pointer never wraps.
module ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [2**AW];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] wrIdx;
  logic [AW-1:0] rdIdx;
  logic          doPush;
  logic          doPop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o && !push_i;
  assign wrIdx   = AW'(cnt_q);
  assign rdIdx   = AW'(cnt_q - 1'b1);
  assign top_o   = mem_q[rdIdx];

  always_comb begin
    cnt_d = cnt_q;
    if (doPush) begin
      cnt_d = cnt_q + 1'b1;
    end else if (doPop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entries are left untouched on reset. An emptied stack never reads them.
  always_ff @(posedge clk_i) begin
    if (reset_i && doPush) begin
      mem_q[wrIdx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It selects the next fetch address from step,
// jump, branch, call and return. It also tracks wrap and sticky stack errors.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              OFF_W       = 6,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  parameter int              STEP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [PC_W-1:0]  target,
  input  logic [OFF_W-1:0] offset,
  input  logic             cond,
  output logic [PC_W-1:0]  pc,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             wrapped,
  output logic             err_ovf,
  output logic             err_udf
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            wrapped_q, wrapped_d;
  logic            errOvf_q, errOvf_d;
  logic            errUdf_q, errUdf_d;

  logic [MAX_W:0]  stepRes;
  logic [MAX_W:0]  branchRes;
  logic [PC_W-1:0] stepPc;
  logic            stepWrap;
  logic [PC_W-1:0] branchPc;
  logic            branchWrap;
  logic [PC_W-1:0] stackTop;
  logic            push;
  logic            pop;
  logic            unusedBits;

  assign stepRes    = addWrap(MAX_W'(pc_q), MAX_W'(STEP), PC_W + 1, PC_W);
  assign branchRes  = addWrap(MAX_W'(pc_q), MAX_W'(offset), OFF_W, PC_W);
  assign stepPc     = stepRes[PC_W-1:0];
  assign stepWrap   = stepRes[MAX_W];
  assign branchPc   = branchRes[PC_W-1:0];
  assign branchWrap = branchRes[MAX_W];
  assign unusedBits = ^{stepRes[MAX_W-1:PC_W], branchRes[MAX_W-1:PC_W]};

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (stepPc),
    .top_o   (stackTop),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  // A CALL on a full stack and a RET on an empty stack both fall through to
  // a plain step. In that case the step's wrap rule still applies.
  always_comb begin
    pc_d      = pc_q;
    wrapped_d = 1'b0;
    errOvf_d  = errOvf_q;
    errUdf_d  = errUdf_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_NEXT: begin
          pc_d      = stepPc;
          wrapped_d = stepWrap;
        end
        OP_JUMP: begin
          pc_d = target;
        end
        OP_BRANCH: begin
          pc_d      = cond ? branchPc : stepPc;
          wrapped_d = cond ? branchWrap : stepWrap;
        end
        OP_CALL: begin
          if (!stack_full) begin
            push = 1'b1;
            pc_d = target;
          end else begin
            pc_d      = stepPc;
            wrapped_d = stepWrap;
            errOvf_d  = 1'b1;
          end
        end
        OP_RET: begin
          if (!stack_empty) begin
            pop  = 1'b1;
            pc_d = stackTop;
          end else begin
            pc_d      = stepPc;
            wrapped_d = stepWrap;
            errUdf_d  = 1'b1;
          end
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_VEC;
      wrapped_q <= 1'b0;
      errOvf_q  <= 1'b0;
      errUdf_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
      errOvf_q  <= errOvf_d;
      errUdf_q  <= errUdf_d;
    end
  end

  assign pc      = pc_q;
  assign wrapped = wrapped_q;
  assign err_ovf = errOvf_q;
  assign err_udf = errUdf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer. The bench compares the DUT
// with an abstract model built from an integer PC and a queue-based stack.
module tb_pc_sequencer;

  localparam int PC_W        = 8;
  localparam int OFF_W       = 6;
  localparam int STACK_DEPTH = 4;
  localparam int RESET_VEC   = 0;
  localparam int STEP        = 1;
  localparam int MOD         = 1 << PC_W;
  localparam int OFF_SPAN    = 1 << OFF_W;

  localparam int HOLD = 0, NEXT = 1, JUMP = 2, BRANCH = 3, CALL = 4, RET = 5;

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       op;
  logic [PC_W-1:0]  target;
  logic [OFF_W-1:0] offset;
  logic             cond;
  logic [PC_W-1:0]  pc;
  logic             stack_full;
  logic             stack_empty;
  logic             wrapped;
  logic             err_ovf;
  logic             err_udf;

  int errCount;
  int checkCount;

  int mPc;
  int mWrap;
  int mOvf;
  int mUdf;
  int mStack[$];

  pc_sequencer #(
    .PC_W        (PC_W),
    .OFF_W       (OFF_W),
    .STACK_DEPTH (STACK_DEPTH),
    .RESET_VEC   (PC_W'(RESET_VEC)),
    .STEP        (STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .cond        (cond),
    .pc          (pc),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .wrapped     (wrapped),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep();
    int nxt;
    nxt   = mPc + STEP;
    mWrap = (nxt >= MOD) ? 1 : 0;
    mPc   = nxt % MOD;
  endtask

  // Update the model from the pre-edge state, clock once, then compare every output.
  task automatic applyStimulus(input logic rstN, input logic enI, input int opI,
                               input int tgtI, input int offI, input logic condI);
    int off;
    int nxt;
    reset  = rstN;
    en     = enI;
    op     = 3'(opI);
    target = PC_W'(tgtI);
    offset = OFF_W'(offI);
    cond   = condI;
    if (!rstN) begin
      mPc = RESET_VEC;
      mWrap = 0;
      mOvf = 0;
      mUdf = 0;
      mStack.delete();
    end else if (!enI) begin
      mWrap = 0;
    end else begin
      case (opI)
        NEXT: modelStep();
        JUMP: begin
          mPc = tgtI;
          mWrap = 0;
        end
        BRANCH: begin
          if (condI) begin
            off   = (offI >= OFF_SPAN / 2) ? offI - OFF_SPAN : offI;
            nxt   = mPc + off;
            mWrap = (nxt < 0 || nxt >= MOD) ? 1 : 0;
            mPc   = (nxt + MOD) % MOD;
          end else begin
            modelStep();
          end
        end
        CALL: begin
          if (mStack.size() < STACK_DEPTH) begin
            mStack.push_back((mPc + STEP) % MOD);
            mPc = tgtI;
            mWrap = 0;
          end else begin
            modelStep();
            mOvf = 1;
          end
        end
        RET: begin
          if (mStack.size() > 0) begin
            mPc = mStack.pop_back();
            mWrap = 0;
          end else begin
            modelStep();
            mUdf = 1;
          end
        end
        default: mWrap = 0;
      endcase
    end
    @(posedge clk);
    #1;
    checkOutput("pc", int'(pc), mPc);
    checkOutput("wrapped", int'(wrapped), mWrap);
    checkOutput("stack_full", int'(stack_full), (mStack.size() == STACK_DEPTH) ? 1 : 0);
    checkOutput("stack_empty", int'(stack_empty), (mStack.size() == 0) ? 1 : 0);
    checkOutput("err_ovf", int'(err_ovf), mOvf);
    checkOutput("err_udf", int'(err_udf), mUdf);
  endtask

  initial begin
    errCount = 0;
    checkCount = 0;
    reset = 1'b0;
    en = 1'b1;
    op = 3'd0;
    target = '0;
    offset = '0;
    cond = 1'b0;

    // Reset held while NEXT is requested, then five sequential steps.
    applyStimulus(1'b0, 1'b1, NEXT, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, NEXT, 0, 0, 1'b0);
    checkOutput("resetPc", int'(pc), RESET_VEC);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, NEXT, 0, 0, 1'b0);
    checkOutput("seqPc5", int'(pc), 5);

    // Wrap at the top of the address space, with a stall in the middle.
    applyStimulus(1'b1, 1'b1, JUMP, 'hFE, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, NEXT, 0, 0, 1'b0);
    checkOutput("prewrapPc", int'(pc), 'hFF);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, NEXT, 0, 0, 1'b0);
    checkOutput("stallPc", int'(pc), 'hFF);
    applyStimulus(1'b1, 1'b1, NEXT, 0, 0, 1'b0);
    checkOutput("wrapPulse", int'(wrapped), 1);
    applyStimulus(1'b1, 1'b1, NEXT, 0, 0, 1'b0);

    // Branches: taken backward, not taken, and a backward underflow.
    applyStimulus(1'b1, 1'b1, JUMP, 'h10, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, BRANCH, 0, 'b111101, 1'b1);
    checkOutput("branchBack", int'(pc), 'h0D);
    applyStimulus(1'b1, 1'b1, JUMP, 'h10, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, BRANCH, 0, 'b111101, 1'b0);
    checkOutput("branchNot", int'(pc), 'h11);
    applyStimulus(1'b1, 1'b1, JUMP, 'h02, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, BRANCH, 0, 'b111100, 1'b1);
    checkOutput("branchUdf", int'(pc), 'hFE);
    checkOutput("branchUdfWrap", int'(wrapped), 1);

    // Nested calls and returns.
    applyStimulus(1'b1, 1'b1, JUMP, 'h20, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, CALL, 'h40, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, CALL, 'h60, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, RET, 0, 0, 1'b0);
    checkOutput("ret1", int'(pc), 'h41);
    applyStimulus(1'b1, 1'b1, RET, 0, 0, 1'b0);
    checkOutput("ret2", int'(pc), 'h21);

    // Overflow of the stack, then unwinding in reverse order.
    applyStimulus(1'b0, 1'b1, HOLD, 0, 0, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, CALL, i * 'h10, 0, 1'b0);
    checkOutput("ovfFallPc", int'(pc), 'h41);
    checkOutput("ovfFlag", int'(err_ovf), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, RET, 0, 0, 1'b0);
    checkOutput("unwindPc", int'(pc), 'h01);

    // Underflow, then a reset taken mid-stack.
    applyStimulus(1'b0, 1'b1, HOLD, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, JUMP, 'h33, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, RET, 0, 0, 1'b0);
    checkOutput("udfPc", int'(pc), 'h34);
    applyStimulus(1'b1, 1'b1, CALL, 'h50, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, CALL, 'h70, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, CALL, 'h90, 0, 1'b0);
    checkOutput("rstErrClr", int'(err_udf), 0);
    applyStimulus(1'b1, 1'b1, RET, 0, 0, 1'b0);

    // Random traffic, biased toward calls and returns so the stack fills and drains.
    for (int i = 0; i < 600; i++) begin
      int r;
      int opSel;
      r = int'($urandom_range(0, 9));
      opSel = (r < 3) ? int'($urandom_range(0, 7)) : ((r < 6) ? CALL : ((r < 8) ? RET : BRANCH));
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0), opSel,
                    int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, OFF_SPAN - 1)),
                    1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the next-generation Marche datapath, which adds control-transfer instructions. It supports sequential stepping, absolute jump, conditional PC-relative branch, and call/return through an internal return-address stack. It drives the instruction-fetch address each cycle and sits between the decode stage (op/target/offset/cond) and instruction memory.

Parameters:
PC_W, 8, PC and address width in bits (>=2)
OFF_W, 6, signed branch-offset width in bits (<=PC_W)
STACK_DEPTH, 4, return-stack entries (>=1)
RESET_VEC, 0, PC value loaded on reset (PC_W bits)
STEP, 1, sequential increment (>=1, <2^PC_W)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous active-low reset
en  input  1  advance enable; 0 = stall, all state held
op  input  3  0 HOLD, 1 NEXT, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6-7 treated as HOLD
target  input  PC_W  absolute destination for JUMP/CALL
offset  input  OFF_W  signed two's-complement displacement for BRANCH
cond  input  1  branch-taken condition, sampled only for BRANCH
pc  output  PC_W  current fetch address (registered)
stack_full  output  1  depth count == STACK_DEPTH
stack_empty  output  1  depth count == 0
wrapped  output  1  one-cycle pulse: last PC update overflowed/underflowed modulo 2^PC_W
err_ovf  output  1  sticky: CALL attempted while full
err_udf  output  1  sticky: RET attempted while empty

Behaviour:
- Reset: reset reset, synchronous, active-low; clock clk. On posedge with reset==0: pc=RESET_VEC, stack depth=0 (stack_empty=1, stack_full=0), wrapped=0, err_ovf=0, err_udf=0. Stack RAM contents need not be cleared. Reset overrides en and op.
- All outputs are registered. An op sampled at edge N is reflected on pc after edge N, with zero extra latency. No combinational input-to-output paths.
- en==0: pc, stack, depth and errors are held. wrapped=0.
- HOLD (and op 6/7): pc held, wrapped=0.
- NEXT: pc <= pc+STEP mod 2^PC_W. wrapped=1 if the carry-out is set.
- JUMP: pc <= target. wrapped=0.
- BRANCH: if cond, pc <= pc + sign_extend(offset) mod 2^PC_W, and wrapped=1 on unsigned carry (positive offset) or borrow (negative offset). If !cond, behaves as NEXT.
- CALL, not full: push pc+STEP (mod 2^PC_W) onto stack, depth+1, pc <= target. The wrapped flag is not set by the return-address computation.
- CALL, full: no push, depth unchanged, pc <= pc+STEP (falls through, NEXT wrap rules apply), err_ovf <= 1.
- RET, not empty: pc <= top-of-stack, depth-1. wrapped=0.
- RET, empty: pc <= pc+STEP (falls through), err_udf <= 1.
- err_ovf/err_udf remain set until reset.
- Stack is LIFO. The internal pointer never wraps; full and empty are derived from depth only.
- Mid-operation reset discards all stack contents and errors in the same edge.

Decomposition:
- Shared package pc_seq_pkg holds:
  - op encoding constants (OP_HOLD..OP_RET);
  - function for sign-extend plus modular add with wrap flag.
- One natural sub-module, ret_stack: parametrised LIFO (PC_W x STACK_DEPTH) with push, pop, top, full, empty. The top level contains PC register, next-PC mux, error and wrapped logic.

Test Plan:
- Reset then 5x NEXT with defaults -> pc 0,1,2,3,4,5. stack_empty=1, all flags 0. Hold reset=0 with op=NEXT -> pc stays 0.
- pc=8'hFE, NEXT x2 -> pc FF then 00, with wrapped=1 only in the cycle pc=00. en=0 for 3 cycles mid-sequence -> pc frozen, wrapped=0.
- pc=8'h10, BRANCH offset=-3 (6'b111101) cond=1 -> pc 8'h0D. Same with cond=0 -> 8'h11. pc=8'h02, offset=-4 -> 8'hFE with wrapped=1.
- Nested CALLs: pc=8'h20, CALL 8'h40, then CALL 8'h60 at 8'h40 -> stack holds 21,41. RET -> 41, RET -> 21, stack_empty=1.
- 5 CALLs with STACK_DEPTH=4 -> stack_full after 4th. 5th CALL gives pc+1, err_ovf=1 and stays set. Then 4 RETs return in reverse order.
- RET on empty stack at pc=8'h33 -> pc 8'h34, err_udf=1. Assert reset=0 mid-stack (depth 2) -> pc=RESET_VEC, depth 0, both errors cleared next cycle.
